// File: rtl/ibex_data_sram_bridge.sv
// Bridges the ibex data port (req/gnt/rvalid) to RW port 0 of the single-port data SRAM macro.
// One access in flight; out-of-window accesses complete with an error response and are logged.
module ibex_data_sram_bridge #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic                  data_err_o,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_addr_i,
  input  logic [31:0]           data_wdata_i,
  output logic [31:0]           data_rdata_o,
  output logic                  sram_csb0_o,
  output logic                  sram_web0_o,
  output logic [3:0]            sram_wmask0_o,
  output logic [ADDR_WIDTH-1:0] sram_addr0_o,
  output logic [31:0]           sram_din0_o,
  input  logic [31:0]           sram_dout0_i,
  output logic [31:0]           err_addr_o,
  output logic [7:0]            err_count_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [32:0] WIN_BASE  = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_SIZE  = 33'd4 << ADDR_WIDTH;
  localparam logic [2:0]  WAIT_INIT = 3'(WAIT_STATES);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic        in_range_q, in_range_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;

  logic [32:0] win_offset;
  logic        in_range;
  logic        sram_sel;

  // Addresses below the base borrow into bit 32, which puts them above WIN_SIZE.
  assign win_offset = {1'b0, data_addr_i} - WIN_BASE;
  assign in_range   = (win_offset < WIN_SIZE);
  assign sram_sel   = in_range && !(data_we_i && (data_be_i == 4'h0));

  assign sram_wmask0_o = data_be_i;
  assign sram_addr0_o  = data_addr_i[ADDR_WIDTH+1:2];
  assign sram_din0_o   = data_wdata_i;
  assign data_rdata_o  = rdata_q;
  assign err_addr_o    = err_addr_q;
  assign err_count_o   = err_count_q;

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    in_range_d    = in_range_q;
    addr_d        = addr_q;
    rdata_d       = rdata_q;
    err_addr_d    = err_addr_q;
    err_count_d   = err_count_q;
    wait_cnt_d    = wait_cnt_q;
    data_gnt_o    = 1'b0;
    data_rvalid_o = 1'b0;
    data_err_o    = 1'b0;
    sram_csb0_o   = 1'b1;
    sram_web0_o   = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        data_gnt_o = data_req_i;
        if (data_req_i && sram_sel) begin
          sram_csb0_o = 1'b0;
          sram_web0_o = ~data_we_i;
        end
        if (data_req_i) begin
          we_d       = data_we_i;
          in_range_d = in_range;
          addr_d     = data_addr_i;
          state_d    = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (!we_q && in_range_q) begin
          rdata_d = sram_dout0_i;
        end
        wait_cnt_d = WAIT_INIT;
        state_d    = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q - 3'd1;
        if (wait_cnt_q <= 3'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        data_rvalid_o = 1'b1;
        data_err_o    = !in_range_q;
        if (!in_range_q) begin
          err_addr_d = addr_q;
          if (err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
          end
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The flops clear asynchronously, but the combinational handshake must be quiet too.
    if (reset) begin
      data_gnt_o  = 1'b0;
      sram_csb0_o = 1'b1;
      sram_web0_o = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      in_range_q  <= 1'b0;
      addr_q      <= '0;
      rdata_q     <= '0;
      err_addr_q  <= '0;
      err_count_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      in_range_q  <= in_range_d;
      addr_q      <= addr_d;
      rdata_q     <= rdata_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_ibex_data_sram_bridge.sv
// Bench for ibex_data_sram_bridge: one bridge with no wait states, one with three, each on its own SRAM model.
module tb_ibex_data_sram_bridge;

  logic        clk;
  logic        reset;
  logic        req0, req3, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;

  logic        g0, rv0, e0, cs0, wb0;
  logic [3:0]  wm0;
  logic [7:0]  sa0, ec0;
  logic [31:0] rd0, din0, dout0, ea0;
  logic        g3, rv3, e3, cs3, wb3;
  logic [3:0]  wm3;
  logic [7:0]  sa3, ec3;
  logic [31:0] rd3, din3, dout3, ea3;

  logic [31:0] sram0 [256];
  logic [31:0] sram3 [256];

  int checks = 0;
  int passed = 0;

  logic [7:0]  m_mem [1024];
  int          m_cnt;
  logic [31:0] m_eaddr;
  logic [31:0] m_rdata;

  logic        use3;
  logic        gnt_s, rvalid_s, err_s, csb_s, web_s;
  logic [3:0]  wmask_s;
  logic [31:0] rdata_s, eaddr_s;
  logic [7:0]  ecnt_s;

  assign gnt_s    = use3 ? g3  : g0;
  assign rvalid_s = use3 ? rv3 : rv0;
  assign err_s    = use3 ? e3  : e0;
  assign csb_s    = use3 ? cs3 : cs0;
  assign web_s    = use3 ? wb3 : wb0;
  assign wmask_s  = use3 ? wm3 : wm0;
  assign rdata_s  = use3 ? rd3 : rd0;
  assign eaddr_s  = use3 ? ea3 : ea0;
  assign ecnt_s   = use3 ? ec3 : ec0;

  ibex_data_sram_bridge #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset),
    .data_req_i(req0), .data_gnt_o(g0), .data_rvalid_o(rv0), .data_err_o(e0),
    .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rdata_o(rd0),
    .sram_csb0_o(cs0), .sram_web0_o(wb0), .sram_wmask0_o(wm0), .sram_addr0_o(sa0),
    .sram_din0_o(din0), .sram_dout0_i(dout0),
    .err_addr_o(ea0), .err_count_o(ec0)
  );

  ibex_data_sram_bridge #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset),
    .data_req_i(req3), .data_gnt_o(g3), .data_rvalid_o(rv3), .data_err_o(e3),
    .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rdata_o(rd3),
    .sram_csb0_o(cs3), .sram_web0_o(wb3), .sram_wmask0_o(wm3), .sram_addr0_o(sa3),
    .sram_din0_o(din3), .sram_dout0_i(dout3),
    .err_addr_o(ea3), .err_count_o(ec3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM macros: masked write, registered read data.
  always @(posedge clk) begin
    if (!cs0) begin
      if (!wb0) begin
        for (int b = 0; b < 4; b++) if (wm0[b]) sram0[sa0][8*b +: 8] <= din0[8*b +: 8];
      end else begin
        dout0 <= sram0[sa0];
      end
    end
  end

  always @(posedge clk) begin
    if (!cs3) begin
      if (!wb3) begin
        for (int b = 0; b < 4; b++) if (wm3[b]) sram3[sa3][8*b +: 8] <= din3[8*b +: 8];
      end else begin
        dout3 <= sram3[sa3];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  // Reference model of the 1 KiB window at address 0: byte memory plus error log.
  task automatic model(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                       output logic x_err, output logic [31:0] x_rd, output logic x_sel);
    logic inr;
    int   base;
    inr  = (a < 32'h400);
    base = int'(a[9:2]) * 4;
    x_err = !inr;
    x_sel = inr && !(w && (b == 4'h0));
    if (!inr) begin
      m_eaddr = a;
      if (m_cnt < 255) m_cnt++;
    end else if (w) begin
      for (int i = 0; i < 4; i++) if (b[i]) m_mem[base + i] = d[8*i +: 8];
    end else begin
      m_rdata = {m_mem[base + 3], m_mem[base + 2], m_mem[base + 1], m_mem[base]};
    end
    x_rd = m_rdata;
  endtask

  task automatic access(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                        output logic g, output logic cs, output logic wb, output logic [3:0] wm,
                        output int lat, output logic e, output logic [31:0] rd);
    @(posedge clk); #1;
    if (use3) req3 = 1'b1; else req0 = 1'b1;
    we = w; be = b; addr = a; wdata = d;
    @(negedge clk);
    g = gnt_s; cs = csb_s; wb = web_s; wm = wmask_s;
    lat = -1; e = 1'b0; rd = '0;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk); #1;
      req0 = 1'b0; req3 = 1'b0;
      @(negedge clk);
      if (rvalid_s) begin
        lat = i; e = err_s; rd = rdata_s;
        break;
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  task automatic run0(input string tag, input logic w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d, input logic use_tbl, input logic t_err, input logic [31:0] t_rd);
    logic x_err, x_sel, g, cs, wb, e, nw, ncs;
    logic [31:0] x_rd, rd;
    logic [3:0] wm;
    int lat;
    model(w, b, a, d, x_err, x_rd, x_sel);
    if (use_tbl) begin
      x_err = t_err;
      x_rd  = t_rd;
    end
    access(w, b, a, d, g, cs, wb, wm, lat, e, rd);
    nw  = ~w;
    ncs = ~x_sel;
    chk({tag, " gnt"}, g, 1);
    chk({tag, " csb0"}, cs, ncs);
    if (x_sel) begin
      chk({tag, " web0"}, wb, nw);
      chk({tag, " wmask0"}, wm, b);
    end
    chk({tag, " latency"}, lat, 2);
    chk({tag, " err"}, e, x_err);
    chk({tag, " rdata"}, rd, x_rd);
    chk({tag, " err_count"}, ecnt_s, m_cnt);
    chk({tag, " err_addr"}, eaddr_s, m_eaddr);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, passed=%0d total=%0d", passed, checks);
    $fatal(1);
  end

  initial begin
    logic g, cs, wb, e;
    logic [3:0] wm;
    logic [31:0] rd;
    int lat;

    tbl[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 4'h1, 32'h0000_0010, 32'h0000_00AA, 1'b0, 32'hDEAD_BEEF};
    tbl[3]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEAA};
    tbl[4]  = '{1'b0, 4'hF, 32'h0000_0400, 32'h0000_0000, 1'b1, 32'hDEAD_BEAA};
    tbl[5]  = '{1'b1, 4'h0, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'hDEAD_BEAA};
    tbl[6]  = '{1'b0, 4'hF, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h0000_0000};
    tbl[7]  = '{1'b1, 4'hF, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'h0000_0000};
    tbl[8]  = '{1'b0, 4'hF, 32'h0000_03FF, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
    tbl[9]  = '{1'b1, 4'hF, 32'hFFFF_FFFC, 32'h1111_1111, 1'b1, 32'hCAFE_F00D};
    tbl[10] = '{1'b1, 4'hA, 32'h0000_0024, 32'hA1B2_C3D4, 1'b0, 32'hCAFE_F00D};
    tbl[11] = '{1'b0, 4'hF, 32'h0000_0026, 32'h0000_0000, 1'b0, 32'hA100_C300};

    for (int i = 0; i < 256; i++) begin
      sram0[i] = '0;
      sram3[i] = '0;
    end
    for (int i = 0; i < 1024; i++) m_mem[i] = '0;
    m_cnt = 0; m_eaddr = '0; m_rdata = '0;
    dout0 = '0; dout3 = '0;

    use3 = 1'b0;
    reset = 1'b1;
    req0 = 1'b1; req3 = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h10; wdata = '0;

    // Reset state, with requests pending that must not be granted.
    @(negedge clk);
    chk("reset gnt", g0, 0);
    chk("reset csb0", cs0, 1);
    chk("reset rvalid", rv0, 0);
    chk("reset rdata", rd0, 0);
    chk("reset err_count", ec0, 0);
    chk("reset err_addr", ea0, 0);
    @(posedge clk); #1;
    reset = 1'b0; req0 = 1'b0; req3 = 1'b0;

    for (int i = 0; i < 12; i++)
      run0($sformatf("tbl%0d", i), tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata,
           1'b1, tbl[i].exp_err, tbl[i].exp_rdata);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      logic w;
      logic [3:0] b;
      case ($urandom_range(0, 9))
        0:       a = 32'h400 + ($urandom() % 32'hFFFF_FC00);
        1:       a = $urandom_range(0, 32'h3FF);
        default: a = $urandom_range(0, 63);
      endcase
      w = 1'($urandom_range(0, 1));
      b = 4'($urandom_range(0, 15));
      run0($sformatf("rnd%0d", i), w, b, a, $urandom(), 1'b0, 1'b0, 32'h0);
    end

    for (int i = 0; i < 250; i++)
      run0($sformatf("sat%0d", i), 1'b0, 4'hF, 32'h800 + 32'(i * 4), 32'h0, 1'b0, 1'b0, 32'h0);
    chk("saturated err_count", ec0, 8'hFF);

    // Back-to-back reads with req held high.
    for (int i = 0; i < 4; i++)
      run0($sformatf("b2b_pre%0d", i), 1'b1, 4'hF, 32'(4 * i), 32'h1000_0000 + 32'(i * 32'h111),
           1'b0, 1'b0, 32'h0);
    begin
      int gc[$];
      int rc[$];
      logic [31:0] rdq[$];
      int k;
      logic gs;
      @(posedge clk); #1;
      req0 = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0; k = 0;
      for (int c = 0; c < 14; c++) begin
        @(negedge clk);
        gs = g0;
        if (gs) begin gc.push_back(c); k++; end
        if (rv0) begin rc.push_back(c); rdq.push_back(rd0); end
        @(posedge clk); #1;
        if (gs) begin
          if (k == 4) req0 = 1'b0;
          else addr = 32'(4 * k);
        end
      end
      chk("b2b grant count", gc.size(), 4);
      chk("b2b rvalid count", rc.size(), 4);
      for (int j = 0; j < gc.size(); j++) chk($sformatf("b2b grant%0d cycle", j), gc[j], 3 * j);
      for (int j = 0; j < rc.size(); j++) begin
        chk($sformatf("b2b rvalid%0d cycle", j), rc[j], 3 * j + 2);
        chk($sformatf("b2b rdata%0d", j), rdq[j], 32'h1000_0000 + 32'(j * 32'h111));
      end
      m_rdata = 32'h1000_0333;
    end

    // Three wait states.
    use3 = 1'b1;
    access(1'b1, 4'hF, 32'h0, 32'h5A5A_1234, g, cs, wb, wm, lat, e, rd);
    chk("ws3 write gnt", g, 1);
    chk("ws3 write latency", lat, 5);
    chk("ws3 write err", e, 0);
    begin
      int rvc, nrv, gbad;
      logic g_first;
      logic [31:0] rdv;
      rvc = -1; nrv = 0; gbad = 0; rdv = '0; g_first = 1'b0;
      @(posedge clk); #1;
      req3 = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (c == 0) g_first = g3;
        else if (c <= 5 && g3) gbad++;
        if (rv3) begin
          nrv++;
          if (rvc < 0) begin rvc = c; rdv = rd3; end
        end
        @(posedge clk); #1;
        if (c == 5) req3 = 1'b0;
      end
      chk("ws3 first gnt", g_first, 1);
      chk("ws3 gnt while busy", gbad, 0);
      chk("ws3 rvalid cycle", rvc, 5);
      chk("ws3 rvalid count", nrv, 1);
      chk("ws3 rdata", rdv, 32'h5A5A_1234);
    end
    use3 = 1'b0;

    // Reset during the CAPTURE cycle of a read.
    begin
      int nrv;
      nrv = 0;
      @(posedge clk); #1;
      req0 = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h10;
      @(negedge clk);
      chk("rst-mid gnt", g0, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("rst-mid gnt forced", g0, 0);
      chk("rst-mid csb0", cs0, 1);
      chk("rst-mid rvalid", rv0, 0);
      chk("rst-mid rdata", rd0, 0);
      chk("rst-mid err_count", ec0, 0);
      chk("rst-mid err_addr", ea0, 0);
      @(posedge clk); #1;
      @(negedge clk);
      if (rv0) nrv++;
      @(posedge clk); #1;
      reset = 1'b0; req0 = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (rv0) nrv++;
      end
      chk("rst-mid dropped rvalid", nrv, 0);
      m_cnt = 0; m_eaddr = '0; m_rdata = '0;
      run0("post-reset read", 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
